// File: rtl/rv_pkg.sv
// rv_pkg: shared types and constants for the multi-cycle RV32I core.
// Opcodes, funct3 codes, FSM states, ALU/writeback selects, decoded bundle.
package rv_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [2:0] {
        FETCH, DECODE, EXEC, MEM, WB, HALT
    } state_e;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_e;

    typedef enum logic [2:0] {
        WB_NONE, WB_ALU, WB_MEM, WB_PC4, WB_IMM, WB_PCIMM
    } wb_sel_e;

    typedef enum logic [2:0] {
        IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
    } imm_fmt_e;

    typedef struct packed {
        alu_op_e     alu_op;
        logic [31:0] imm;
        wb_sel_e     wb_sel;
        logic        src_imm;
        logic        is_load;
        logic        is_store;
        logic        is_branch;
        logic        is_jal;
        logic        is_jalr;
        logic        illegal;
    } dec_t;

    function automatic logic [31:0] alu_eval(
        input alu_op_e     op,
        input logic [31:0] a,
        input logic [31:0] b
    );
        logic [4:0] sh;
        sh = b[4:0];
        case (op)
            ALU_SUB:  alu_eval = a - b;
            ALU_SLL:  alu_eval = a << sh;
            ALU_SLT:  alu_eval = {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU: alu_eval = {31'b0, a < b};
            ALU_XOR:  alu_eval = a ^ b;
            ALU_SRL:  alu_eval = a >> sh;
            ALU_SRA:  alu_eval = $signed(a) >>> sh;
            ALU_OR:   alu_eval = a | b;
            ALU_AND:  alu_eval = a & b;
            default:  alu_eval = a + b;
        endcase
    endfunction

endpackage

// File: rtl/rv_decoder.sv
// rv_decoder: combinational RV32I instruction decoder.
// ir_i: instruction word; dec_o: decoded control bundle with immediate.
module rv_decoder
    import rv_pkg::*;
(
    input  logic [31:0] ir_i,
    output dec_t        dec_o
);

    logic [6:0] opc;
    logic [2:0] f3;
    imm_fmt_e   fmt;

    assign opc = ir_i[6:0];
    assign f3  = ir_i[14:12];

    // sub_en selects SUB on funct3 000; sra_en selects SRA on funct3 101
    function automatic alu_op_e f3_op(
        input logic [2:0] fn,
        input logic       sub_en,
        input logic       sra_en
    );
        case (fn)
            F3_ADD:  f3_op = sub_en ? ALU_SUB : ALU_ADD;
            F3_SLL:  f3_op = ALU_SLL;
            F3_SLT:  f3_op = ALU_SLT;
            F3_SLTU: f3_op = ALU_SLTU;
            F3_XOR:  f3_op = ALU_XOR;
            F3_SR:   f3_op = sra_en ? ALU_SRA : ALU_SRL;
            F3_OR:   f3_op = ALU_OR;
            default: f3_op = ALU_AND;
        endcase
    endfunction

    always_comb begin
        dec_o        = '0;
        dec_o.alu_op = ALU_ADD;
        dec_o.wb_sel = WB_NONE;
        fmt          = IMM_I;
        case (opc)
            OPC_LUI: begin
                fmt          = IMM_U;
                dec_o.wb_sel = WB_IMM;
            end
            OPC_AUIPC: begin
                fmt          = IMM_U;
                dec_o.wb_sel = WB_PCIMM;
            end
            OPC_JAL: begin
                fmt          = IMM_J;
                dec_o.wb_sel = WB_PC4;
                dec_o.is_jal = 1'b1;
            end
            OPC_JALR: begin
                dec_o.wb_sel  = WB_PC4;
                dec_o.is_jalr = 1'b1;
            end
            OPC_BRANCH: begin
                fmt             = IMM_B;
                dec_o.is_branch = 1'b1;
            end
            OPC_LOAD: begin
                dec_o.wb_sel  = WB_MEM;
                dec_o.src_imm = 1'b1;
                dec_o.is_load = 1'b1;
            end
            OPC_STORE: begin
                fmt            = IMM_S;
                dec_o.src_imm  = 1'b1;
                dec_o.is_store = 1'b1;
            end
            OPC_OPIMM: begin
                dec_o.wb_sel  = WB_ALU;
                dec_o.src_imm = 1'b1;
                dec_o.alu_op  = f3_op(f3, 1'b0, ir_i[30]);
            end
            OPC_OP: begin
                dec_o.wb_sel = WB_ALU;
                dec_o.alu_op = f3_op(f3, ir_i[30], ir_i[30]);
            end
            default: dec_o.illegal = 1'b1;
        endcase
        case (fmt)
            IMM_S: dec_o.imm = {{20{ir_i[31]}}, ir_i[31:25], ir_i[11:7]};
            IMM_B: dec_o.imm = {{19{ir_i[31]}}, ir_i[31], ir_i[7],
                                ir_i[30:25], ir_i[11:8], 1'b0};
            IMM_U: dec_o.imm = {ir_i[31:12], 12'b0};
            IMM_J: dec_o.imm = {{11{ir_i[31]}}, ir_i[31], ir_i[19:12],
                                ir_i[20], ir_i[30:21], 1'b0};
            default: dec_o.imm = {{20{ir_i[31]}}, ir_i[31:20]};
        endcase
    end

endmodule

// File: rtl/rv_core_mc.sv
// rv_core_mc: multi-cycle RV32I core (FETCH/DECODE/EXEC/MEM/WB/HALT).
// Ports: CLK/RST, imem req/addr/rvalid/rdata, dmem req/we/be/addr/wdata/ack/rdata, retire, halted.
module rv_core_mc
    import rv_pkg::*;
#(
    parameter int          IADDR_W  = 10,
    parameter int          DADDR_W  = 10,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               CLK,
    input  logic               RST,
    output logic               imem_req,
    output logic [IADDR_W-1:0] imem_addr,
    input  logic               imem_rvalid,
    input  logic [31:0]        imem_rdata,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [3:0]         dmem_be,
    output logic [DADDR_W-1:0] dmem_addr,
    output logic [31:0]        dmem_wdata,
    input  logic               dmem_ack,
    input  logic [31:0]        dmem_rdata,
    output logic               retire,
    output logic               halted
);

    state_e      state_q;
    logic [31:0] pc_q, ir_q, a_q, b_q, alu_q, npc_q, ld_q;
    logic [31:0] rf_q [1:31];

    dec_t        dec;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic [31:0] rs1_val, rs2_val, op_b, alu_res;
    logic [31:0] pc_imm, npc, wb_val, rd_sh, ld_val;
    logic [1:0]  boff;
    logic        taken, mis;
    logic [3:0]  be;

    rv_decoder u_dec (
        .ir_i  (ir_q),
        .dec_o (dec)
    );

    assign rs1  = ir_q[19:15];
    assign rs2  = ir_q[24:20];
    assign rd   = ir_q[11:7];
    assign f3   = ir_q[14:12];
    assign boff = alu_q[1:0];

    assign rs1_val = (rs1 == 5'd0) ? 32'd0 : rf_q[rs1];
    assign rs2_val = (rs2 == 5'd0) ? 32'd0 : rf_q[rs2];

    assign op_b    = dec.src_imm ? dec.imm : b_q;
    assign alu_res = alu_eval(dec.alu_op, a_q, op_b);
    assign pc_imm  = pc_q + dec.imm;

    always_comb begin
        case (f3)
            F3_BEQ:  taken = (a_q == b_q);
            F3_BNE:  taken = (a_q != b_q);
            F3_BLT:  taken = ($signed(a_q) < $signed(b_q));
            F3_BGE:  taken = ($signed(a_q) >= $signed(b_q));
            F3_BLTU: taken = (a_q < b_q);
            F3_BGEU: taken = (a_q >= b_q);
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        if (dec.is_jal || (dec.is_branch && taken))
            npc = pc_imm;
        else if (dec.is_jalr)
            npc = (a_q + dec.imm) & ~32'd1;
        else
            npc = pc_q + 32'd4;
    end

    // size is funct3[1:0]: 00 byte, 01 half, 1x word
    assign mis = (f3[1:0] == 2'b01 && boff[0])
               || (f3[1] && boff != 2'b00);

    always_comb begin
        case (f3[1:0])
            2'b00:   begin be = 4'b0001 << boff; dmem_wdata = {4{b_q[7:0]}};  end
            2'b01:   begin be = 4'b0011 << boff; dmem_wdata = {2{b_q[15:0]}}; end
            default: begin be = 4'b1111;         dmem_wdata = b_q;            end
        endcase
    end

    assign rd_sh = dmem_rdata >> {boff, 3'b000};

    always_comb begin
        case (f3)
            F3_LB:   ld_val = {{24{rd_sh[7]}}, rd_sh[7:0]};
            F3_LH:   ld_val = {{16{rd_sh[15]}}, rd_sh[15:0]};
            F3_LBU:  ld_val = {24'd0, rd_sh[7:0]};
            F3_LHU:  ld_val = {16'd0, rd_sh[15:0]};
            default: ld_val = rd_sh;
        endcase
    end

    always_comb begin
        case (dec.wb_sel)
            WB_MEM:   wb_val = ld_q;
            WB_PC4:   wb_val = pc_q + 32'd4;
            WB_IMM:   wb_val = dec.imm;
            WB_PCIMM: wb_val = pc_imm;
            default:  wb_val = alu_q;
        endcase
    end

    // Requests are state decodes, also masked while RST is high
    assign imem_req  = (state_q == FETCH) && !RST;
    assign imem_addr = pc_q[IADDR_W+1:2];
    assign dmem_req  = (state_q == MEM) && !mis && !RST;
    assign dmem_we   = dmem_req && dec.is_store;
    assign dmem_be   = dmem_req ? be : 4'b0000;
    assign dmem_addr = alu_q[DADDR_W+1:2];
    assign retire    = (state_q == WB);
    assign halted    = (state_q == HALT);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            alu_q   <= '0;
            npc_q   <= '0;
            ld_q    <= '0;
        end else begin
            case (state_q)
                FETCH: if (imem_rvalid) begin
                    ir_q    <= imem_rdata;
                    state_q <= DECODE;
                end
                DECODE: begin
                    a_q     <= rs1_val;
                    b_q     <= rs2_val;
                    state_q <= dec.illegal ? HALT : EXEC;
                end
                EXEC: begin
                    alu_q <= alu_res;
                    npc_q <= npc;
                    if (npc[1])
                        state_q <= HALT;
                    else if (dec.is_load || dec.is_store)
                        state_q <= MEM;
                    else
                        state_q <= WB;
                end
                MEM: begin
                    if (mis) begin
                        state_q <= HALT;
                    end else if (dmem_ack) begin
                        ld_q    <= ld_val;
                        state_q <= WB;
                    end
                end
                WB: begin
                    pc_q    <= npc_q;
                    state_q <= FETCH;
                end
                default: state_q <= HALT;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST && state_q == WB && rd != 5'd0 && dec.wb_sel != WB_NONE)
            rf_q[rd] <= wb_val;
    end

endmodule

// File: tb/tb_rv_core_mc.sv
// tb_rv_core_mc: directed bench for rv_core_mc with wait-state memory models.
// Results are observed through fetch addresses, store traffic, retire and halted.
module tb_rv_core_mc;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        imem_req, imem_rvalid;
    logic [9:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [3:0]  dmem_be;
    logic [9:0]  dmem_addr;
    logic [31:0] dmem_wdata, dmem_rdata;
    logic        retire, halted;

    int   iwait = 0, dwait = 0, icnt = 0, dcnt = 0;
    logic dack_force = 1'b0;

    logic [31:0] imem [0:1023];
    logic [31:0] dmem [0:1023];

    rv_core_mc #(
        .IADDR_W  (10),
        .DADDR_W  (10),
        .RESET_PC (32'h0000_0100)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_be     (dmem_be),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .dmem_ack    (dmem_ack),
        .dmem_rdata  (dmem_rdata),
        .retire      (retire),
        .halted      (halted)
    );

    initial forever #5 CLK = ~CLK;

    assign imem_rvalid = imem_req && (icnt >= iwait);
    assign imem_rdata  = imem[imem_addr];
    assign dmem_ack    = (dmem_req && (dcnt >= dwait)) || dack_force;
    assign dmem_rdata  = dmem[dmem_addr];

    always @(posedge CLK) begin
        icnt <= (imem_req && !imem_rvalid) ? icnt + 1 : 0;
        dcnt <= (dmem_req && !dmem_ack) ? dcnt + 1 : 0;
        if (dmem_req && dmem_ack && dmem_we)
            for (int k = 0; k < 4; k++)
                if (dmem_be[k])
                    dmem[dmem_addr][k*8 +: 8] <= dmem_wdata[k*8 +: 8];
    end

    int n_chk = 0, n_fail = 0;

    task automatic expect_eq(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [31:0] imm,
        input logic [4:0] rs1, input logic [2:0] f3,
        input logic [4:0] rd, input logic [6:0] op);
        return {imm[11:0], rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [31:0] imm,
        input logic [4:0] rs2, input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_b(input logic [31:0] imm,
        input logic [4:0] rs2, input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_j(input logic [31:0] imm,
        input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7,
        input logic [4:0] rs2, input logic [4:0] rs1,
        input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction

    logic [3:0]  l_be;
    logic [9:0]  l_addr;
    logic [31:0] l_wdata;
    logic        l_we;
    int          dreq_n;
    logic        ia_bad;

    // Entered in the FETCH cycle (after the negedge); leaves positioned in
    // the following cycle. cyc counts the instruction's cycles.
    task automatic step(output int cyc, output int nret);
        logic [9:0] ia0;
        bit first;
        cyc = 1; nret = 0; dreq_n = 0; ia_bad = 1'b0; first = 1'b1; ia0 = '0;
        forever begin
            if (imem_req) begin
                if (!first && imem_addr != ia0) ia_bad = 1'b1;
                ia0 = imem_addr;
                first = 1'b0;
            end
            if (dmem_req) begin
                dreq_n++;
                l_be = dmem_be; l_addr = dmem_addr;
                l_wdata = dmem_wdata; l_we = dmem_we;
            end
            if (retire) nret++;
            if (retire || halted || cyc >= 40) break;
            @(negedge CLK);
            cyc++;
        end
        @(negedge CLK);
    endtask

    task automatic run1(input string tag, input int exp_cyc);
        int c, r;
        step(c, r);
        expect_eq({tag, "/cycles"}, c, exp_cyc);
        expect_eq({tag, "/retire"}, r, 1);
    endtask

    task automatic store_chk(input string tag, input int exp_cyc,
        input logic [3:0] be, input logic [9:0] addr, input logic [31:0] wd);
        run1(tag, exp_cyc);
        expect_eq({tag, "/we"}, l_we, 1);
        expect_eq({tag, "/be"}, l_be, be);
        expect_eq({tag, "/addr"}, l_addr, addr);
        expect_eq({tag, "/wdata"}, l_wdata, wd);
    endtask

    task automatic do_reset(input string tag);
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        expect_eq({tag, "/rst_outs"},
                  {imem_req, dmem_req, dmem_we, retire, halted, dmem_be}, 0);
        RST = 1'b0;
        #1;
        expect_eq({tag, "/first_req"}, imem_req, 1);
        expect_eq({tag, "/first_addr"}, imem_addr, 10'h040);
    endtask

    task automatic idle_chk(input string tag);
        int n = 0;
        repeat (5) begin
            @(negedge CLK);
            if (imem_req || dmem_req || retire || !halted) n++;
        end
        expect_eq(tag, n, 0);
    endtask

    initial begin
        int c, r;
        for (int i = 0; i < 1024; i++) imem[i] = 32'h0;

        imem['h40] = enc_i(-5, 0, 3'b000, 1, 7'h13);
        imem['h41] = enc_s(0, 1, 0, 3'b010);
        imem['h42] = enc_i(32'h20, 0, 3'b000, 2, 7'h13);
        imem['h43] = {20'h80C10, 5'd1, 7'h37};
        imem['h44] = enc_i(-239, 1, 3'b000, 1, 7'h13);
        imem['h45] = enc_s(0, 1, 2, 3'b010);
        imem['h46] = enc_s(3, 1, 2, 3'b000);
        imem['h47] = enc_i(-128, 0, 3'b000, 4, 7'h13);
        imem['h48] = enc_s(3, 4, 2, 3'b000);
        imem['h49] = enc_i(3, 2, 3'b000, 3, 7'h03);
        imem['h4A] = enc_s(4, 3, 2, 3'b010);
        imem['h4B] = enc_i(3, 2, 3'b100, 3, 7'h03);
        imem['h4C] = enc_s(4, 3, 2, 3'b010);
        imem['h4D] = enc_i(2, 2, 3'b001, 5, 7'h03);
        imem['h4E] = enc_s(4, 5, 2, 3'b010);
        imem['h4F] = enc_s(2, 1, 2, 3'b001);
        imem['h50] = enc_i(32'h404, 1, 3'b101, 6, 7'h13);
        imem['h51] = enc_s(0, 6, 0, 3'b010);
        imem['h52] = enc_r(7'h20, 1, 2, 3'b000, 7);
        imem['h53] = enc_s(0, 7, 0, 3'b010);
        imem['h54] = enc_i(-1, 0, 3'b000, 1, 7'h13);
        imem['h55] = enc_i(1, 0, 3'b000, 2, 7'h13);
        imem['h56] = enc_b(8, 2, 1, 3'b100);
        imem['h57] = 32'h0000_007F;
        imem['h58] = enc_b(8, 2, 1, 3'b110);
        imem['h59] = enc_j(8, 9);
        imem['h5A] = 32'h0000_007F;
        imem['h5B] = enc_s(0, 9, 0, 3'b010);
        imem['h5C] = {20'h00001, 5'd10, 7'h17};
        imem['h5D] = enc_s(0, 10, 0, 3'b010);
        imem['h5E] = enc_i(32'h200, 0, 3'b000, 1, 7'h13);
        imem['h5F] = enc_i(3, 1, 3'b000, 5, 7'h67);

        do_reset("A");
        run1("addi", 4);
        expect_eq("retire_once", retire, 0);
        store_chk("sw_x1", 5, 4'b1111, 10'h000, 32'hFFFF_FFFB);
        iwait = 3;
        run1("fetch_wait", 7);
        expect_eq("fetch_addr_stable", ia_bad, 0);
        iwait = 0;
        run1("lui", 4);
        run1("addi_lo", 4);
        store_chk("sw", 5, 4'b1111, 10'h008, 32'h80C0_FF11);
        store_chk("sb", 5, 4'b1000, 10'h008, 32'h1111_1111);
        run1("addi_m128", 4);
        store_chk("sb80", 5, 4'b1000, 10'h008, 32'h8080_8080);
        dwait = 2;
        run1("lb_wait", 7);
        expect_eq("lb_we", l_we, 0);
        dwait = 0;
        store_chk("lb_val", 5, 4'b1111, 10'h009, 32'hFFFF_FF80);
        run1("lbu", 5);
        store_chk("lbu_val", 5, 4'b1111, 10'h009, 32'h0000_0080);
        run1("lh", 5);
        store_chk("lh_val", 5, 4'b1111, 10'h009, 32'hFFFF_80C0);
        store_chk("sh", 5, 4'b1100, 10'h008, 32'hFF11_FF11);
        run1("srai", 4);
        store_chk("srai_val", 5, 4'b1111, 10'h000, 32'hF80C_0FF1);
        run1("sub", 4);
        store_chk("sub_val", 5, 4'b1111, 10'h000, 32'h7F3F_010F);
        run1("li_m1", 4);
        run1("li_1", 4);
        run1("blt", 4);
        expect_eq("blt_target", imem_addr, 10'h058);
        run1("bltu", 4);
        expect_eq("bltu_target", imem_addr, 10'h059);
        run1("jal", 4);
        expect_eq("jal_target", imem_addr, 10'h05B);
        store_chk("jal_link", 5, 4'b1111, 10'h000, 32'h0000_0168);
        run1("auipc", 4);
        store_chk("auipc_val", 5, 4'b1111, 10'h000, 32'h0000_1170);
        run1("li_200", 4);
        step(c, r);
        expect_eq("jalr_mis/cycles", c, 4);
        expect_eq("jalr_mis/retire", r, 0);
        idle_chk("jalr_mis/halt_idle");

        imem['h40] = 32'h0000_007F;
        do_reset("B");
        step(c, r);
        expect_eq("illegal/cycles", c, 3);
        expect_eq("illegal/retire", r, 0);
        idle_chk("illegal/halt_idle");

        imem['h40] = enc_i(32'h22, 0, 3'b000, 2, 7'h13);
        imem['h41] = enc_i(0, 2, 3'b010, 3, 7'h03);
        do_reset("C");
        run1("addi_22", 4);
        step(c, r);
        expect_eq("lw_mis/cycles", c, 5);
        expect_eq("lw_mis/no_req", dreq_n, 0);
        expect_eq("lw_mis/retire", r, 0);

        imem['h40] = enc_i(32'h20, 0, 3'b000, 2, 7'h13);
        imem['h41] = enc_i(0, 2, 3'b010, 3, 7'h03);
        do_reset("D");
        run1("addi_20", 4);
        dwait = 5;
        c = 0;
        while (!dmem_req && c < 10) begin
            @(negedge CLK);
            c++;
        end
        expect_eq("mid_rst/req_seen", dmem_req, 1);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        expect_eq("mid_rst/req_drop", dmem_req, 0);
        imem['h40] = enc_i(1, 0, 3'b000, 0, 7'h13);
        imem['h41] = enc_s(0, 0, 0, 3'b010);
        dwait = 0;
        dack_force = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        #1;
        expect_eq("mid_rst/restart_pc", imem_addr, 10'h040);
        run1("addi_x0", 4);
        dack_force = 1'b0;
        store_chk("x0_zero", 5, 4'b1111, 10'h000, 32'h0000_0000);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
